// File: rtl/lab3_adder_subtractor_serial_if.sv
`default_nettype none
// ============================================================================
// lab3_adder_subtractor_serial_if: start/busy/done bus of the serial add/sub
// Revision: 1.0
// ============================================================================
interface lab3_adder_subtractor_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             K;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;
   logic             zero;

   modport master (
      output start, a, b, K,
      input  busy, done, sum, cout, overflow, zero
   );

   modport slave (
      input  start, a, b, K,
      output busy, done, sum, cout, overflow, zero
   );
endinterface
`default_nettype wire

// File: rtl/lab3_adder_subtractor_serial.sv
`default_nettype none
// ============================================================================
// lab3_adder_subtractor_serial: WIDTH-bit add/sub, DIGIT bits per clock
// Revision: 1.0
// ============================================================================
module lab3_adder_subtractor_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input logic                           clk,
   input logic                           rst,
   lab3_adder_subtractor_serial_if.slave bus
);
   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   generate
      if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
         $error("lab3_adder_subtractor_serial: WIDTH must be a multiple of DIGIT");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             mode;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;

   logic [DIGIT-1:0] slice_s;
   logic             slice_c;
   logic [WIDTH-1:0] sum_next;

   // Operands shift right each cycle, so the current chunk is always in the low DIGIT bits.
   assign {slice_c, slice_s} = {1'b0, a_sh[DIGIT-1:0]}
                             + {1'b0, b_sh[DIGIT-1:0] ^ {DIGIT{mode}}}
                             + {{DIGIT{1'b0}}, carry};

   always_comb begin
      sum_next = sum_q;
      for (int j = 0; j < N; j++) begin
         if (cnt == CW'(j)) begin
            sum_next[j*DIGIT +: DIGIT] = slice_s;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         mode   <= 1'b0;
         carry  <= 1'b0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sh   <= bus.a;
                  b_sh   <= bus.b;
                  mode   <= bus.K;
                  carry  <= bus.K;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            RUN: begin
               sum_q <= sum_next;
               carry <= slice_c;
               cnt   <= cnt + CW'(1);
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               if (cnt == LAST) begin
                  // On the last chunk the low bits of the shifted operands hold the sign bits.
                  state  <= DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  cout_q <= slice_c;
                  ovf_q  <= (a_sh[DIGIT-1] == (b_sh[DIGIT-1] ^ mode)) &&
                            (slice_s[DIGIT-1] != a_sh[DIGIT-1]);
                  zero_q <= (sum_next == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
endmodule
`default_nettype wire

// File: doc/lab3_adder_subtractor_serial.md
# lab3_adder_subtractor_serial

Parametrised multi-cycle adder/subtractor: processes a WIDTH-bit add or two's-complement subtract DIGIT bits per clock using a single DIGIT-wide adder slice and a registered carry. Trades latency for area. Sits between operand registers and result consumers with a start/busy/done handshake, and adds signed-overflow and zero flags that the combinational add/sub lacks. Generalises the ripple add/sub in width, in chunk size, and in sequencing.

## Interface
- WIDTH, default 8: operand and result width in bits; must be ≥ 1.
- DIGIT, default 2: bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT must be 0, otherwise elaboration fails.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- K  input  1  mode, captured on an accepted start: 0 = a+b, 1 = a−b (~b+1).
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; held until the next accepted start completes.
- cout  output  1  final carry-out. For subtract, 1 = no borrow (unsigned a ≥ b).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  high when sum == 0.

## Operation
- N = WIDTH/DIGIT chunks.
- Internal state: operand regs, K reg, carry reg, chunk counter of width clog2(N), and result reg.
- FSM has three states: IDLE, RUN, DONE.
- IDLE / DONE with start=1:
  - Capture a, b, K.
  - Set carry reg to K and counter to 0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: go to IDLE.
- RUN, each cycle, on chunk k = counter:
  - Compute {c, s} = a[k] + (b[k] ^ {DIGIT{K}}) + carry.
  - Write s into sum bits [k·DIGIT +: DIGIT]. Carry reg ← c. Counter increments.
- RUN on the last chunk (k = N−1):
  - Go to DONE.
  - Register cout = c.
  - Register overflow = (a_msb == bx_msb) && (s_msb != a_msb), where bx = b ^ {WIDTH{K}}.
  - Register zero from the complete new sum.
- start is ignored while in RUN; the captured operands are unaffected.
- sum, cout, overflow, zero update only in RUN; they are stable in IDLE, DONE and the following IDLE.
- Intermediate sum bits are visible during RUN. Consumers use them only on done or after it.
- Widths: the adder slice is DIGIT+1 bits. No sign extension. Arithmetic wraps modulo 2^WIDTH.
- DIGIT == WIDTH is legal: N = 1, single RUN cycle.

## Timing
- Reset (async, immediate):
  - State goes to IDLE; counter and carry reg clear.
  - busy=0, done=0, sum=0, cout=0, overflow=0, zero=0.
- Reset mid-RUN aborts the operation. No done is produced. Outputs take their reset values.
- Latency:
  - start accepted at edge E0; busy=1 from E0 to E0+N.
  - Chunk k is written at edge E0+k+1.
  - done=1 and final flags are valid for exactly one cycle after edge E0+N; busy=0 in that cycle.
- Back-to-back operation: start=1 during the DONE cycle is accepted. The next RUN begins with no idle gap, giving a throughput of one result per N+1 cycles.
- start held high continuously restarts after every DONE. Each result still pulses done once.
- Operands a, b and K may change freely after the accepting edge.

## Test plan
All cases use WIDTH=8, DIGIT=2, so N=4.
- Add, no overflow: a=100, b=27, K=0, start → done 4 cycles later; sum=127, cout=0, overflow=0, zero=0; busy high for exactly 4 cycles.
- Add, signed overflow: a=100, b=28, K=0 → sum=0x80, overflow=1, cout=0. Then a=0xFF, b=0x01, K=0 → sum=0x00, cout=1, zero=1, overflow=0.
- Subtract with borrow, then overflow: a=5, b=7, K=1 → sum=0xFE, cout=0, overflow=0. Then a=0x80, b=0x01, K=1 → sum=0x7F, cout=1, overflow=1.
- Back-to-back with busy-time start:
  - Issue 42−42, then hold start high with new operands 3+4.
  - Required: result 0 with zero=1, cout=1; then 7 with done exactly 5 cycles after the first done.
  - A start pulse mid-RUN with different operands is ignored.
- Reset mid-operation: assert rst after the second RUN cycle → busy, done, sum, flags all 0 immediately; no done pulse follows. Then 10+20 → sum=30 after 4 cycles.
- Parameter sweep: DIGIT ∈ {1, 2, 4, 8} with WIDTH=8, plus WIDTH=16, DIGIT=4. Random operands and modes are checked against a reference model (a ± b mod 2^WIDTH, carry, overflow, zero). Required latency is N cycles.
